serial_reader_mlane: RTL and testbench

- Multi-lane, parametrised successor of the single-lane weight serialiser in the PE datapath.
- Accepts one packed word of LANES weights per handshake.
- Emits each weight as a sequence of signed power-of-two terms (sign, exp, man), plus a shared bit-significance, one term per cycle for the bit-serial multipliers.
- Supports int8, int6 and int4 (radix-4 Booth) and fp4 E2M1, with valid/ready flow control on both sides.

---
 rtl/serial_reader_mlane.sv | 135 +++++++++++++
 tb/tb_serial_reader_mlane.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reader_mlane.sv
// Multi-lane weight serialiser: each lane's weight becomes signed power-of-two terms (Booth int8/6/4, fp4 E2M1).
// Term 0 appears the cycle after accept; all outputs hold while out_ready is low, and in_ready opens only when IDLE or on the last-term handshake.
module serial_reader_mlane #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_sign,
  output logic [2*LANES-1:0]   out_exp,
  output logic [LANES-1:0]     out_man,
  output logic [2:0]           out_bsig,
  output logic                 out_last
);

  localparam logic [1:0] MODE_INT8 = 2'd0;
  localparam logic [1:0] MODE_INT6 = 2'd1;
  localparam logic [1:0] MODE_FP4  = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [1:0]           cnt, cnt_nxt;
  logic [8*LANES-1:0]   data_r;
  logic [1:0]           mode_r;
  logic [1:0]           last_idx;
  logic                 term_done;
  logic                 accept;

  always_comb begin
    case (mode_r)
      MODE_INT8: last_idx = 2'd3;
      MODE_INT6: last_idx = 2'd2;
      default:   last_idx = 2'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_valid = (state == BUSY);
    out_last  = out_valid & (cnt == last_idx);
    term_done = out_valid & out_ready;
    in_ready  = (state == IDLE) | (term_done & out_last);
    accept    = in_valid & in_ready;
    out_bsig  = (out_valid && mode_r != MODE_FP4) ? {cnt, 1'b0} : 3'd0;
    // A word accepted on the last-term handshake takes priority over returning to IDLE.
    if (accept) begin
      state_nxt = BUSY;
      cnt_nxt   = 2'd0;
    end else if (term_done) begin
      if (out_last) begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end else begin
        cnt_nxt = cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      data_r <= '0;
      mode_r <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        data_r <= in_data;
        mode_r <= in_mode;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [8:0] x;
    logic [2:0] trip;
    logic [1:0] fe;
    logic       fm;
    logic       fs;
    logic       s;
    logic [1:0] e;
    logic       m;

    always_comb begin
      x    = {data_r[8*i +: 8], 1'b0};
      trip = x[{cnt, 1'b0} +: 3];
      fe   = data_r[8*i+1 +: 2];
      fm   = data_r[8*i];
      fs   = data_r[8*i+3];
      s    = 1'b0;
      e    = 2'd0;
      m    = 1'b0;
      if (mode_r == MODE_FP4) begin
        if (cnt == 2'd0) begin
          if (fe == 2'd0) begin
            m = fm;
          end else begin
            m = 1'b1;
            e = fe;
          end
        end else if (fe != 2'd0) begin
          m = fm;
          e = fe - 2'd1;
        end
        // Zero terms are canonical so -0 produces nothing but zeros.
        if (m) begin
          s = fs;
        end else begin
          e = 2'd0;
        end
      end else begin
        case (trip)
          3'b001, 3'b010: begin s = 1'b0; e = 2'd0; m = 1'b1; end
          3'b011:         begin s = 1'b0; e = 2'd1; m = 1'b1; end
          3'b100:         begin s = 1'b1; e = 2'd1; m = 1'b1; end
          3'b101, 3'b110: begin s = 1'b1; e = 2'd0; m = 1'b1; end
          default:        begin s = 1'b0; e = 2'd0; m = 1'b0; end
        endcase
      end
    end

    assign out_sign[i]       = out_valid & s;
    assign out_exp[2*i +: 2] = out_valid ? e : 2'd0;
    assign out_man[i]        = out_valid & m;
  end

endmodule

// File: tb/tb_serial_reader_mlane.sv
// Bench for serial_reader_mlane: directed test-plan words plus random traffic against an arithmetic Booth/fp4 model.
module tb_serial_reader_mlane;
  localparam int LANES = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_mode;
  logic [8*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES-1:0]     out_sign;
  logic [2*LANES-1:0]   out_exp;
  logic [LANES-1:0]     out_man;
  logic [2:0]           out_bsig;
  logic                 out_last;

  serial_reader_mlane #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
    .out_bsig(out_bsig), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  w_mode[$];
  logic [31:0] w_data[$];
  bit          m_busy;
  int          m_term;
  logic [1:0]  m_mode;
  logic [31:0] m_data;
  int          sum[LANES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int nterms(input logic [1:0] md);
    case (md)
      2'd0:    return 4;
      2'd1:    return 3;
      default: return 2;
    endcase
  endfunction

  // Numeric value of one lane's field: integers as two's complement, fp4 in half-units.
  function automatic int field_value(input logic [1:0] md, input logic [7:0] d);
    int v;
    int ee;
    case (md)
      2'd0: v = int'($signed(d));
      2'd1: begin v = int'(d[5:0]); if (v >= 32) v -= 64; end
      2'd2: begin v = int'(d[3:0]); if (v >= 8) v -= 16; end
      default: begin
        ee = int'(d[2:1]);
        v  = (ee == 0) ? int'(d[0]) : ((2 + int'(d[0])) << (ee - 1));
        if (d[3]) v = -v;
      end
    endcase
    return v;
  endfunction

  task automatic expect_term(input logic [1:0] md, input logic [31:0] d32, input int t,
                             output logic [3:0] es, output logic [7:0] ee, output logic [3:0] em,
                             output logic [2:0] eb);
    logic [7:0] d;
    logic [8:0] x;
    int dig;
    int fexp;
    int fman;
    es = '0; ee = '0; em = '0;
    eb = (md == 2'd3) ? 3'd0 : 3'(2 * t);
    for (int l = 0; l < LANES; l++) begin
      d = d32[8*l +: 8];
      if (md == 2'd3) begin
        fexp = 0;
        fman = 0;
        if (t == 0) begin
          if (d[2:1] == 2'd0) fman = int'(d[0]);
          else begin fman = 1; fexp = int'(d[2:1]); end
        end else if (d[2:1] != 2'd0) begin
          fman = int'(d[0]);
          fexp = (fman != 0) ? int'(d[2:1]) - 1 : 0;
        end
        em[l]       = (fman != 0);
        es[l]       = d[3] && (fman != 0);
        ee[2*l +: 2] = 2'(fexp);
      end else begin
        x   = {d, 1'b0};
        dig = int'(x[2*t]) + int'(x[2*t+1]) - 2 * int'(x[2*t+2]);
        es[l]        = (dig < 0);
        em[l]        = (dig != 0);
        ee[2*l +: 2] = (dig == 2 || dig == -2) ? 2'd1 : 2'd0;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_terms"}, {16'd0, out_exp, out_sign, out_man}, 32'd0);
    check({tag, "_bsig_last"}, {28'd0, out_bsig, out_last}, 32'd0);
  endtask

  // Drives queued words, cycle by cycle, against a transaction-level model of the handshake.
  task automatic run(input int stall_term, input int stall_len, input bit rnd, input int stop_term);
    int budget;
    int stall_left;
    int tv;
    bit last;
    bit eready;
    bit hs;
    bit acc;
    logic [3:0] es;
    logic [7:0] ee;
    logic [3:0] em;
    logic [2:0] eb;
    budget     = 0;
    stall_left = stall_len;
    while ((w_mode.size() > 0 || m_busy) && budget < 400) begin
      @(negedge clk);
      budget++;
      if (stop_term >= 0 && m_busy && m_term == stop_term) break;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else if (m_busy && m_term == stall_term && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = 1'b1;
      if (w_mode.size() > 0 && !(rnd && $urandom_range(0, 4) == 0)) begin
        in_valid = 1'b1;
        in_mode  = w_mode[0];
        in_data  = w_data[0];
      end else begin
        in_valid = 1'b0;
        in_mode  = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      #1;
      last   = m_busy && (m_term == nterms(m_mode) - 1);
      eready = !m_busy || (out_ready && last);
      check("in_ready", 32'(in_ready), 32'(eready));
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("out_last", 32'(out_last), 32'(last));
      if (m_busy) expect_term(m_mode, m_data, m_term, es, ee, em, eb);
      else begin es = '0; ee = '0; em = '0; eb = '0; end
      check("out_sign", 32'(out_sign), 32'(es));
      check("out_exp", 32'(out_exp), 32'(ee));
      check("out_man", 32'(out_man), 32'(em));
      check("out_bsig", 32'(out_bsig), 32'(eb));
      hs = m_busy && out_ready;
      if (hs) begin
        for (int l = 0; l < LANES; l++) begin
          tv = out_man[l] ? (1 << (int'(out_exp[2*l +: 2]) + int'(out_bsig))) : 0;
          sum[l] += out_sign[l] ? -tv : tv;
        end
        if (last) begin
          for (int l = 0; l < LANES; l++) begin
            check("word_sum", sum[l], field_value(m_mode, m_data[8*l +: 8]));
            sum[l] = 0;
          end
        end
      end
      acc = in_valid && eready;
      if (hs) begin
        if (last) m_busy = 1'b0;
        else m_term++;
      end
      if (acc) begin
        m_busy = 1'b1;
        m_term = 0;
        m_mode = w_mode.pop_front();
        m_data = w_data.pop_front();
      end
    end
    if (stop_term < 0) check("drained", 32'(w_mode.size() == 0 && !m_busy), 32'd1);
  endtask

  task automatic push(input logic [1:0] md, input logic [31:0] d);
    w_mode.push_back(md);
    w_data.push_back(d);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_mode   = 2'd0;
    in_data   = '0;
    m_busy    = 1'b0;
    m_term    = 0;
    m_mode    = 2'd0;
    m_data    = '0;
    for (int l = 0; l < LANES; l++) sum[l] = 0;

    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("after_reset");

    // int8: 0x7F and 0x80 extremes
    push(2'd0, 32'h55_00_80_7F);
    run(-1, 0, 1'b0, -1);

    // int6: upper bits set must be ignored
    push(2'd1, 32'hC0_FF_E0_DF);
    push(2'd1, 32'h00_3F_20_1F);
    run(-1, 0, 1'b0, -1);

    // fp4: -6, 1.5, 0.5, -0
    push(2'd3, 32'h08_01_03_0F);
    run(-1, 0, 1'b0, -1);

    // Backpressure at term 1 for 3 cycles
    push(2'd0, 32'h9C_3B_E7_A5);
    run(1, 3, 1'b0, -1);

    // Back-to-back int4 then int8 with in_valid held high
    push(2'd2, 32'h8F_7A_96_C3);
    push(2'd0, 32'h12_F0_6D_81);
    run(-1, 0, 1'b0, -1);

    // Reset in the middle of an int8 word
    push(2'd0, 32'hA5_5A_FF_7F);
    run(-1, 0, 1'b0, 2);
    check("pre_reset_busy", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    m_busy = 1'b0;
    m_term = 0;
    for (int l = 0; l < LANES; l++) sum[l] = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("post_reset");
    @(negedge clk);
    #1;
    check_idle_outputs("post_reset_hold");
    push(2'd0, 32'h01_80_40_C3);
    run(-1, 0, 1'b0, -1);

    // Random traffic with random stalls and gaps
    repeat (40) push(2'($urandom_range(0, 3)), $urandom);
    run(-1, 0, 1'b1, -1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
